wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset, sampled on rising clk.
REQ-003 SHALL have port RegWrite, input, 1, writeback enable from the MEM/WB pipeline register.
REQ-004 SHALL have port MemToReg, input, 1, writeback source select: 1 = memory read data, 0 = ALU/address result.
REQ-005 SHALL have port MemAddr, input, 32, ALU result carried through MEM/WB.
REQ-006 SHALL have port MemReadData, input, 32, data-memory read result carried through MEM/WB.
REQ-007 SHALL have port RdAddr, input, 5, destination register index.
REQ-008 SHALL have port RsAddr, input, 5, read port A index from ID stage.
REQ-009 SHALL have port RtAddr, input, 5, read port B index from ID stage.
REQ-010 SHALL have port RsData, output, 32, read port A data.
REQ-011 SHALL have port RtData, output, 32, read port B data.
REQ-012 SHALL have port WbData, output, 32, currently selected writeback value (combinational).
REQ-013 SHALL have port WbCommit, output, 1, high when current inputs constitute an effective write (RegWrite=1 and RdAddr!=0).
REQ-014 SHALL have port CommitCount, output, 32, registered count of effective writes since reset.
REQ-015 SHALL have port WrittenMask, output, 32, registered flag per register, bit i set once register i has been written since reset.

Function
REQ-016 SHALL compute WbData = MemToReg ? MemReadData : MemAddr, purely combinational.
REQ-017 SHALL hold 32 registers of 32 bits; register 0 reads 0 always and is never written.
REQ-018 SHALL write WbData into register RdAddr on rising clk when WbCommit=1; no write otherwise.
REQ-019 SHALL drive RsData/RtData combinationally from the indexed register; index 0 returns 0.
REQ-020 SHALL bypass: when WbCommit=1 and RsAddr==RdAddr (nonzero), RsData = WbData in the same cycle; same rule for RtData/RtAddr.
REQ-021 SHALL apply bypass independently to both ports; Rs and Rt naming the same register both return the bypassed value.
REQ-022 SHALL increment CommitCount by 1 on each rising clk with WbCommit=1; wraps 0xFFFFFFFF -> 0x00000000 without flag.
REQ-023 SHALL set WrittenMask[RdAddr] on each committed write; bit 0 stays 0; bits never clear except by reset.
REQ-024 SHALL treat RegWrite=1 with RdAddr=0 as a no-op: no write, no count, WbCommit=0, no bypass.
REQ-025 SHALL treat X-free inputs only; MemToReg ignored for WbData when irrelevant but WbData still driven.
REQ-026 Latency: write visible via register array on cycle after the edge; via bypass in the same cycle.

Reset
REQ-027 SHALL, when rst=1 at rising clk, clear all registers to 0, CommitCount to 0, WrittenMask to 0.
REQ-028 SHALL give rst priority over a simultaneous write: the write is discarded and not counted.
REQ-029 SHALL keep combinational outputs functional during reset: RsData/RtData reflect bypass of WbData if WbCommit=1, else array contents.
REQ-030 SHALL resume normal writes on the first rising clk with rst=0.

Verification
REQ-031 Reset then RegWrite=1, MemToReg=0, MemAddr=0x0000_1234, RdAddr=5, one edge -> RsAddr=5 gives 0x0000_1234, CommitCount=1, WrittenMask=0x0000_0020.
REQ-032 RegWrite=1, MemToReg=1, MemReadData=0xDEAD_BEEF, RdAddr=7, RsAddr=RtAddr=7 before edge -> RsData=RtData=0xDEAD_BEEF same cycle (bypass).
REQ-033 RegWrite=1, RdAddr=0, MemAddr=0xFFFF_FFFF -> WbCommit=0, after edge reg 0 reads 0, CommitCount unchanged.
REQ-034 rst=1 together with RegWrite=1, RdAddr=3, MemAddr=0x55 -> after edge reg 3 reads 0, CommitCount=0, WrittenMask=0.
REQ-035 RegWrite=0, MemAddr=0xAA, RdAddr=9, RsAddr=9 -> RsData = old reg 9 value, no count change, WbData=0xAA.
REQ-036 Force CommitCount to 0xFFFF_FFFF (by preload or 2^32 writes in formal/backdoor) then one committed write -> CommitCount=0.

Source files
------------

// File: rtl/wb_regfile.sv
// MEM/WB writeback stage and 32x32 register file with same-cycle bypass,
// a commit counter and a sticky per-register written mask.

module wb_regfile_rd_port (
  input  logic [31:0][31:0] regs,
  input  logic [4:0]        addr,
  input  logic              byp_en,
  input  logic [4:0]        byp_addr,
  input  logic [31:0]       byp_data,
  output logic [31:0]       data
);
  // byp_en already excludes index 0, so a zero index always falls to the array/zero path
  always_comb begin
    data = '0;
    if (byp_en && addr == byp_addr) data = byp_data;
    else if (addr != '0)            data = regs[addr];
  end
endmodule

module wb_regfile #(
  // reset value of the commit counter; nonzero only to exercise wrap-around
  parameter logic [31:0] COUNT_RESET = '0,
  parameter int          NUM_RD      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite,
  input  logic        MemToReg,
  input  logic [31:0] MemAddr,
  input  logic [31:0] MemReadData,
  input  logic [4:0]  RdAddr,
  input  logic [4:0]  RsAddr,
  input  logic [4:0]  RtAddr,
  output logic [31:0] RsData,
  output logic [31:0] RtData,
  output logic [31:0] WbData,
  output logic        WbCommit,
  output logic [31:0] CommitCount,
  output logic [31:0] WrittenMask
);
  logic [31:0][31:0]       regs;
  logic [NUM_RD-1:0][4:0]  rd_addr;
  logic [NUM_RD-1:0][31:0] rd_data;

  assign WbData   = MemToReg ? MemReadData : MemAddr;
  assign WbCommit = RegWrite && (RdAddr != '0);

  assign rd_addr = {RtAddr, RsAddr};
  assign RsData  = rd_data[0];
  assign RtData  = rd_data[1];

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    wb_regfile_rd_port u_rd (
      .regs     (regs),
      .addr     (rd_addr[p]),
      .byp_en   (WbCommit),
      .byp_addr (RdAddr),
      .byp_data (WbData),
      .data     (rd_data[p])
    );
  end

  // reset wins over a coincident commit: nothing written, nothing counted
  always_ff @(posedge clk) begin
    if (rst) begin
      regs        <= '0;
      CommitCount <= COUNT_RESET;
      WrittenMask <= '0;
    end else if (WbCommit) begin
      regs[RdAddr]        <= WbData;
      CommitCount         <= CommitCount + 32'd1;
      WrittenMask[RdAddr] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_regfile.sv
// Randomized bench for wb_regfile against an array/counter model, plus
// literal anchor cases and a counter wrap check on a preloaded instance.

module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst, RegWrite, MemToReg;
  logic [31:0] MemAddr, MemReadData;
  logic [4:0]  RdAddr, RsAddr, RtAddr;
  logic [31:0] RsData, RtData, WbData, CommitCount, WrittenMask;
  logic        WbCommit;
  logic [31:0] RsData2, RtData2, WbData2, CommitCount2, WrittenMask2;
  logic        WbCommit2;

  int tests = 0;
  int fails = 0;

  logic [31:0] mreg [32];
  logic [31:0] mcnt, mmask;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .MemAddr(MemAddr), .MemReadData(MemReadData), .RdAddr(RdAddr),
    .RsAddr(RsAddr), .RtAddr(RtAddr), .RsData(RsData), .RtData(RtData),
    .WbData(WbData), .WbCommit(WbCommit), .CommitCount(CommitCount),
    .WrittenMask(WrittenMask)
  );

  wb_regfile #(.COUNT_RESET(32'hFFFF_FFFF)) dut_wrap (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .MemAddr(MemAddr), .MemReadData(MemReadData), .RdAddr(RdAddr),
    .RsAddr(RsAddr), .RtAddr(RtAddr), .RsData(RsData2), .RtData(RtData2),
    .WbData(WbData2), .WbCommit(WbCommit2), .CommitCount(CommitCount2),
    .WrittenMask(WrittenMask2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a, input bit com,
                                         input logic [4:0] rd, input logic [31:0] wb);
    if (a == 5'd0)            return 32'd0;
    if (com && a == rd)       return wb;
    return mreg[a];
  endfunction

  // apply inputs mid-cycle and compare every output against the model
  task automatic drive(input bit r, input bit rw, input bit mtr, input logic [31:0] ma,
                       input logic [31:0] md, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt);
    logic [31:0] wb;
    bit com;
    @(negedge clk);
    rst = r; RegWrite = rw; MemToReg = mtr; MemAddr = ma; MemReadData = md;
    RdAddr = rd; RsAddr = rs; RtAddr = rt;
    #1;
    wb  = mtr ? md : ma;
    com = rw && (rd != 5'd0);
    chk("WbData", WbData, wb);
    chk("WbCommit", {31'd0, WbCommit}, {31'd0, com});
    chk("RsData", RsData, m_read(rs, com, rd, wb));
    chk("RtData", RtData, m_read(rt, com, rd, wb));
    chk("CommitCount", CommitCount, mcnt);
    chk("WrittenMask", WrittenMask, mmask);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
      mcnt = 32'd0; mmask = 32'd0;
    end else if (RegWrite && RdAddr != 5'd0) begin
      mreg[RdAddr] = MemToReg ? MemReadData : MemAddr;
      mcnt = mcnt + 32'd1;
      mmask = mmask | (32'd1 << RdAddr);
    end
    #1;
  endtask

  initial begin
    logic [4:0] rd, rs, rt;
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    mcnt = 32'd0; mmask = 32'd0;
    rst = 1'b1; RegWrite = 1'b0; MemToReg = 1'b0; MemAddr = '0; MemReadData = '0;
    RdAddr = '0; RsAddr = '0; RtAddr = '0;

    drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("rst_count", CommitCount, 32'd0);
    chk("rst_mask", WrittenMask, 32'd0);
    chk("wrap_preload", CommitCount2, 32'hFFFF_FFFF);

    // write 0x1234 to r5, then read it back through the array
    drive(0, 1, 0, 32'h0000_1234, 32'h0, 5, 5, 0);
    chk("byp_r5", RsData, 32'h0000_1234);
    tick();
    chk("cnt_after_r5", CommitCount, 32'd1);
    chk("mask_after_r5", WrittenMask, 32'h0000_0020);
    chk("wrap_to_zero", CommitCount2, 32'd0);
    drive(0, 0, 0, 32'h0, 32'h0, 0, 5, 0);
    chk("array_r5", RsData, 32'h0000_1234);
    tick();

    // both ports bypass from a memory-sourced write to r7
    drive(0, 1, 1, 32'h1111_1111, 32'hDEAD_BEEF, 7, 7, 7);
    chk("byp_rs7", RsData, 32'hDEAD_BEEF);
    chk("byp_rt7", RtData, 32'hDEAD_BEEF);
    tick();

    // write to r0 is a no-op
    drive(0, 1, 0, 32'hFFFF_FFFF, 32'h0, 0, 0, 0);
    chk("r0_commit", {31'd0, WbCommit}, 32'd0);
    chk("r0_rs", RsData, 32'd0);
    tick();
    chk("r0_cnt", CommitCount, 32'd2);
    drive(0, 0, 0, 32'h0, 32'h0, 0, 0, 7);
    chk("r0_after", RsData, 32'd0);
    chk("r7_array", RtData, 32'hDEAD_BEEF);
    tick();

    // no-write: old value seen, WbData still driven
    drive(0, 0, 0, 32'h0000_00AA, 32'h0, 9, 9, 5);
    chk("nowr_wb", WbData, 32'h0000_00AA);
    chk("nowr_rs9", RsData, 32'd0);
    tick();
    chk("nowr_cnt", CommitCount, 32'd2);

    // reset beats a simultaneous write
    drive(1, 1, 0, 32'h0000_0055, 32'h0, 3, 3, 0);
    chk("rst_byp", RsData, 32'h0000_0055);
    tick();
    chk("rst_cnt", CommitCount, 32'd0);
    chk("rst_msk", WrittenMask, 32'd0);
    drive(0, 0, 0, 32'h0, 32'h0, 0, 3, 5);
    chk("rst_r3", RsData, 32'd0);
    chk("rst_r5", RtData, 32'd0);
    tick();

    for (int n = 0; n < 600; n++) begin
      rd = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rs = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 9));
      rt = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
      drive(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
            $urandom, $urandom, rd, rs, rt);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
